// File: rtl/alu8_pkg.sv
// Shared types for the 8-bit ALU command issuer: op codes, flag bit positions, FSM states.
package alu8_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        MUL  = 4'h2,
        DIV  = 4'h3,
        AND  = 4'h4,
        OR   = 4'h5,
        NAND = 4'h6,
        NOR  = 4'h7,
        XOR  = 4'h8,
        XNOR = 4'h9,
        NOT  = 4'hA
    } alu_op_e;

    localparam logic [3:0] OP_MAX = 4'hA;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Divide-by-zero and codes past NOT are reported as errors.
    function automatic logic op_is_err(input logic [3:0] op, input logic [7:0] b);
        return ((op == DIV) && (b == 8'h00)) || (op > OP_MAX);
    endfunction

endpackage

// File: rtl/alu8_cmd_issuer.sv
// Command front end for the combinational 8-bit ALU: registers operands, captures the
// result one cycle later, returns it over a valid/ready channel and keeps an accumulator.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | ALU inputs registered, result captured at the end of this cycle
// RESP  | response held until rsp_ready; may accept the next command in the same cycle
module alu8_cmd_issuer
    import alu8_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_select,
    input  logic [7:0]       alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [7:0]       acc_out,
    output logic [CNT_W-1:0] op_count
);

    state_e           r_state;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [3:0]       r_alu_select;
    logic             r_err;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;
    logic [7:0]       r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic [7:0]       w_opnd_a;

    // In RESP the next command rides on the response handshake, so ready follows rsp_ready.
    assign cmd_ready = !rst && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_opnd_a  = cmd_use_acc ? r_acc : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_select <= 4'h0;
            r_err        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_flags  <= 4'h0;
            r_rsp_err    <= 1'b0;
            r_acc        <= ACC_RESET;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_opnd_a;
                r_alu_b      <= cmd_b;
                r_alu_select <= cmd_op;
                r_err        <= op_is_err(cmd_op, cmd_b);
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= {alu_flags[FLAG_C], alu_flags[FLAG_V],
                                     alu_flags[FLAG_Z], alu_flags[FLAG_N]};
                    r_rsp_err    <= r_err;
                    r_rsp_valid  <= 1'b1;
                    if (!r_err) begin
                        r_acc <= alu_result;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= w_accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_select = r_alu_select;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign acc_out    = r_acc;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu8_cmd_issuer.sv
// Scoreboard bench for alu8_cmd_issuer: a behavioural ALU sits beside each issuer instance,
// directed commands push hand-computed responses, a monitor pops and compares on handshake.
module tb_alu8_cmd_issuer;
    import alu8_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_op = 4'h0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_use_acc = 1'b0;
    logic       rsp_ready = 1'b1;

    logic        cmd_ready, rsp_valid, rsp_err;
    logic [7:0]  alu_a, alu_b, alu_result, rsp_result, acc_out;
    logic [3:0]  alu_select, alu_flags, rsp_flags;
    logic [15:0] op_count;

    logic        cmd_ready_2, rsp_valid_2, rsp_err_2;
    logic [7:0]  alu_a_2, alu_b_2, alu_result_2, rsp_result_2, acc_out_2;
    logic [3:0]  alu_select_2, alu_flags_2, rsp_flags_2;
    logic [1:0]  op_count_2;

    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c, v;
        s = 9'h0; p = 16'h0; r = 8'h0; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: begin p = a * b; r = p[7:0]; c = |p[15:8]; end
            4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = ~(a & b);
            4'h7: r = ~(a | b);
            4'h8: r = a ^ b;
            4'h9: r = ~(a ^ b);
            4'hA: r = ~a;
            default: r = 8'h00;
        endcase
        return {c, v, (r == 8'h00), r[7], r};
    endfunction

    assign {alu_flags, alu_result}     = alu_f(alu_select, alu_a, alu_b);
    assign {alu_flags_2, alu_result_2} = alu_f(alu_select_2, alu_a_2, alu_b_2);

    alu8_cmd_issuer #(.CNT_W(16), .ACC_RESET(8'h00)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(alu_a), .alu_b(alu_b),
        .alu_select(alu_select), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc_out(acc_out), .op_count(op_count)
    );

    alu8_cmd_issuer #(.CNT_W(2), .ACC_RESET(8'h00)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_2), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .alu_a(alu_a_2), .alu_b(alu_b_2),
        .alu_select(alu_select_2), .alu_result(alu_result_2), .alu_flags(alu_flags_2),
        .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready), .rsp_result(rsp_result_2),
        .rsp_flags(rsp_flags_2), .rsp_err(rsp_err_2), .acc_out(acc_out_2), .op_count(op_count_2)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic       err;
        logic [7:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    initial begin
        logic [15:0] m_cnt;
        exp_t        e;
        m_cnt = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt = 16'h0;
            end else begin
                chk("dut2_rsp_valid", {15'h0, rsp_valid_2}, {15'h0, rsp_valid});
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=%h expected=none t=%0t", rsp_result, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_result", {8'h0, rsp_result}, {8'h0, e.res});
                        chk("rsp_flags", {12'h0, rsp_flags}, {12'h0, e.flg});
                        chk("rsp_err", {15'h0, rsp_err}, {15'h0, e.err});
                        chk("acc_out", {8'h0, acc_out}, {8'h0, e.acc});
                        chk("dut2_rsp_result", {8'h0, rsp_result_2}, {8'h0, e.res});
                        chk("op_count", op_count, m_cnt);
                        chk("op_count_cnt2", {14'h0, op_count_2}, {14'h0, m_cnt[1:0]});
                        hs_cyc.push_back(cyc);
                        m_cnt = m_cnt + 16'h1;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua,
                        input logic [7:0] er, input logic [3:0] ef, input logic ee, input logic [7:0] ea);
        exp_t e;
        e = '{er, ef, ee, ea};
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_accept expected=accept op=%h", op);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 16'(exp_q.size()), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);
        chk("rst_alu_a", {8'h0, alu_a}, 16'h0);
        chk("rst_alu_b", {8'h0, alu_b}, 16'h0);
        chk("rst_alu_select", {12'h0, alu_select}, 16'h0);
        chk("rst_acc", {8'h0, acc_out}, 16'h0);
        chk("rst_op_count", op_count, 16'h0);
        chk("rst_cmd_ready", {15'h0, cmd_ready}, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", {15'h0, cmd_ready}, 16'h1);
        @(posedge clk);
        #1;

        // ADD overflow plus latency
        send(4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 1'b0, 8'h80);
        @(negedge clk);
        chk("lat_exec_rsp_valid", {15'h0, rsp_valid}, 16'h0);
        @(negedge clk);
        chk("lat_resp_rsp_valid", {15'h0, rsp_valid}, 16'h1);
        @(posedge clk);
        #1;
        drain();

        // Chained ADD then SUB from accumulator
        send(4'h0, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000, 1'b0, 8'h08);
        drain();
        send(4'h1, 8'hFF, 8'h08, 1'b1, 8'h00, 4'b0010, 1'b0, 8'h00);
        chk("use_acc_alu_a", {8'h0, alu_a}, 16'h0008);
        drain();
        chk("op_count_after_chain", op_count, 16'd3);

        // Error ops leave accumulator alone; boundary codes A (legal) and B (illegal)
        send(4'h0, 8'h20, 8'h22, 1'b0, 8'h42, 4'b0000, 1'b0, 8'h42);
        send(4'h3, 8'h10, 8'h00, 1'b0, 8'h00, 4'b0010, 1'b1, 8'h42);
        send(4'hF, 8'h11, 8'h22, 1'b0, 8'h00, 4'b0010, 1'b1, 8'h42);
        send(4'h3, 8'h10, 8'h03, 1'b0, 8'h05, 4'b0000, 1'b0, 8'h05);
        send(4'h2, 8'h10, 8'h11, 1'b0, 8'h10, 4'b1000, 1'b0, 8'h10);
        send(4'hA, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0001, 1'b0, 8'hF0);
        send(4'hB, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0010, 1'b1, 8'hF0);
        drain();
        chk("acc_after_err", {8'h0, acc_out}, 16'h00F0);

        // Backpressure then back-to-back accepts
        rsp_ready = 1'b0;
        send(4'h8, 8'h5A, 8'hFF, 1'b0, 8'hA5, 4'b0001, 1'b0, 8'hA5);
        cmd_valid = 1'b1; cmd_op = 4'h4; cmd_a = 8'h00; cmd_b = 8'h0F; cmd_use_acc = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {15'h0, rsp_valid}, 16'h1);
            chk("hold_rsp_result", {8'h0, rsp_result}, 16'h00A5);
            chk("hold_rsp_flags", {12'h0, rsp_flags}, 16'h0001);
            chk("hold_cmd_ready", {15'h0, cmd_ready}, 16'h0);
            chk("hold_alu_a", {8'h0, alu_a}, 16'h005A);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("resp_cmd_ready", {15'h0, cmd_ready}, 16'h1);
        exp_q.push_back('{8'h05, 4'b0000, 1'b0, 8'h05});
        @(posedge clk);
        #1;
        send(4'h5, 8'h00, 8'hF0, 1'b1, 8'hF5, 4'b0001, 1'b0, 8'hF5);
        cmd_valid = 1'b0;
        drain();
        n = hs_cyc.size();
        if (n >= 3) begin
            chk("b2b_gap_1", 16'(hs_cyc[n-2] - hs_cyc[n-3]), 16'd2);
            chk("b2b_gap_2", 16'(hs_cyc[n-1] - hs_cyc[n-2]), 16'd2);
        end else begin
            chk("b2b_hs_count", 16'(n), 16'd3);
        end

        // Reset while in EXEC drops the command
        send(4'h1, 8'h03, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b0, 8'h02);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_exec_cmd_ready", {15'h0, cmd_ready}, 16'h0);
        @(negedge clk);
        chk("rst_exec_rsp_valid", {15'h0, rsp_valid}, 16'h0);
        chk("rst_exec_acc", {8'h0, acc_out}, 16'h0);
        chk("rst_exec_op_count", op_count, 16'h0);
        chk("rst_exec_op_count2", {14'h0, op_count_2}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);

        // Counter wrap on the 2-bit instance
        send(4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b0, 8'h02);
        send(4'h0, 8'h00, 8'h01, 1'b1, 8'h03, 4'b0000, 1'b0, 8'h03);
        send(4'h0, 8'h00, 8'h01, 1'b1, 8'h04, 4'b0000, 1'b0, 8'h04);
        send(4'h6, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0010, 1'b0, 8'h00);
        send(4'h7, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0001, 1'b0, 8'hFF);
        drain();
        chk("wrap_op_count", op_count, 16'd5);
        chk("wrap_op_count2", {14'h0, op_count_2}, 16'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
